// File: rtl/hist_eq_pkg.sv
// Shared constants, FSM encoding and LUT saturation helper for the histogram-equalisation LUT builder.
package hist_eq_pkg;

  localparam int BINS    = 256;
  localparam int CNT_W   = 32;
  localparam int LUT_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int LUT_MAX = (1 << LUT_W) - 1;
  localparam int DIV_W   = 40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_HIST = 3'd2,
    READ      = 3'd3,
    ACC       = 3'd4,
    DIV       = 3'd5,
    WRITE     = 3'd6,
    DONE      = 3'd7
  } state_e;

  function automatic logic [LUT_W-1:0] sat_lut(input logic [DIV_W-1:0] q);
    return (q > DIV_W'(LUT_MAX)) ? LUT_W'(LUT_MAX) : q[LUT_W-1:0];
  endfunction

endpackage

// File: rtl/hist_eq_lut_builder_if.sv
// Control, histogram read port and LUT write port of the LUT builder.
// master = the builder; slave = histogram block, remap stage and controller around it.
interface hist_eq_lut_builder_if;

  logic                              start;
  logic [hist_eq_pkg::CNT_W-1:0]     frame_pixels;
  logic                              hist_calc_flag;
  logic                              hist_valid;
  logic                              hist_rd_en;
  logic [hist_eq_pkg::ADDR_W-1:0]    hist_rd_addr;
  logic [hist_eq_pkg::CNT_W-1:0]     hist_rd_data;
  logic                              lut_we;
  logic [hist_eq_pkg::ADDR_W-1:0]    lut_addr;
  logic [hist_eq_pkg::LUT_W-1:0]     lut_data;
  logic                              busy;
  logic                              done;
  logic                              err_timeout;
  logic                              cdf_mismatch;

  modport master (
    input  start, frame_pixels, hist_valid, hist_rd_data,
    output hist_calc_flag, hist_rd_en, hist_rd_addr, lut_we, lut_addr, lut_data,
           busy, done, err_timeout, cdf_mismatch
  );

  modport slave (
    output start, frame_pixels, hist_valid, hist_rd_data,
    input  hist_calc_flag, hist_rd_en, hist_rd_addr, lut_we, lut_addr, lut_data,
           busy, done, err_timeout, cdf_mismatch
  );

endinterface

// File: rtl/hist_eq_lut_builder_seq_divider.sv
// Restoring divider, 40-bit / 32-bit; done pulses 40 cycles after start with quotient valid.
// No backpressure: the first iteration runs in the start cycle; a start while busy restarts it.
module seq_divider
  import hist_eq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic [CNT_W-1:0] rem, rem_in, rem_nxt, dsr, dsr_in;
  logic [DIV_W-1:0] quo_in, quo_nxt;
  logic [CNT_W:0]   trial;
  logic             fits;
  logic [5:0]       cnt;

  // Remainder stays below the divisor, so 32 bits plus the shifted-in bit suffice.
  always_comb begin
    rem_in  = start ? '0 : rem;
    quo_in  = start ? dividend : quotient;
    dsr_in  = start ? divisor : dsr;
    trial   = {rem_in, quo_in[DIV_W-1]};
    fits    = (trial >= {1'b0, dsr_in});
    rem_nxt = fits ? CNT_W'(trial - {1'b0, dsr_in}) : trial[CNT_W-1:0];
    quo_nxt = {quo_in[DIV_W-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      dsr      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        dsr      <= divisor;
        cnt      <= 6'(DIV_W - 1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        cnt      <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hist_eq_lut_builder.sv
// Runs one histogram capture, then streams a 256-entry equalisation LUT: 3 cycles/bin on bypass, 44 when dividing.
// No backpressure: the histogram read data is assumed one cycle after hist_rd_en and LUT writes are never stalled.
module hist_eq_lut_builder
  import hist_eq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd16777216
)
(
  input logic                    clk,
  input logic                    rst,
  hist_eq_lut_builder_if.master  bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);
  localparam logic [LUT_W-1:0]  LUT_TOP  = LUT_W'(LUT_MAX);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] bin;
  logic [CNT_W-1:0]  cdf, cdf_min, frame_px;
  logic              found;
  logic [LUT_W-1:0]  value;
  logic [DIV_W-1:0]  num_q;
  logic [CNT_W-1:0]  den_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              err_timeout_q, cdf_mismatch_q;

  logic [CNT_W:0]    cdf_sum;
  logic [CNT_W-1:0]  cdf_new, cdf_min_new, den_new;
  logic [DIV_W-1:0]  num_new;
  logic              found_new;
  logic              div_start, div_busy, div_done;
  logic [DIV_W-1:0]  div_quotient;

  always_comb begin
    cdf_sum     = {1'b0, cdf} + {1'b0, bus.hist_rd_data};
    cdf_new     = cdf_sum[CNT_W] ? '1 : cdf_sum[CNT_W-1:0];
    found_new   = found | (cdf_new != '0);
    cdf_min_new = found ? cdf_min : cdf_new;
    num_new     = {{(DIV_W-CNT_W){1'b0}}, cdf_new - cdf_min_new} * DIV_W'(LUT_MAX);
    den_new     = (cdf_min_new > frame_px) ? '0 : frame_px - cdf_min_new;
  end

  // Timeout window is measured from the ARM cycle: done lands TIMEOUT cycles after ARM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = ARM;
      ARM:       state_nxt = WAIT_HIST;
      WAIT_HIST: begin
        if (bus.hist_valid)          state_nxt = READ;
        else if (tmo_cnt == TMO_LAST) state_nxt = DONE;
      end
      READ:      state_nxt = ACC;
      ACC:       state_nxt = (found_new && den_new != '0 && num_new != '0) ? DIV : WRITE;
      DIV:       if (div_done) state_nxt = WRITE;
      WRITE:     state_nxt = (bin == LAST_BIN) ? DONE : READ;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin            <= '0;
      cdf            <= '0;
      cdf_min        <= '0;
      frame_px       <= '0;
      found          <= 1'b0;
      value          <= '0;
      num_q          <= '0;
      den_q          <= '0;
      tmo_cnt        <= '0;
      err_timeout_q  <= 1'b0;
      cdf_mismatch_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          frame_px       <= bus.frame_pixels;
          cdf            <= '0;
          cdf_min        <= '0;
          bin            <= '0;
          found          <= 1'b0;
          tmo_cnt        <= '0;
          err_timeout_q  <= 1'b0;
          cdf_mismatch_q <= 1'b0;
        end
        ARM:  tmo_cnt <= tmo_cnt + 1'b1;
        WAIT_HIST: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!bus.hist_valid && tmo_cnt == TMO_LAST) err_timeout_q <= 1'b1;
        end
        ACC: begin
          cdf     <= cdf_new;
          found   <= found_new;
          cdf_min <= cdf_min_new;
          num_q   <= num_new;
          den_q   <= den_new;
          value   <= (found_new && den_new == '0) ? LUT_TOP : '0;
        end
        DIV:   if (div_done) value <= sat_lut(div_quotient);
        WRITE: if (bin != LAST_BIN) bin <= bin + 1'b1;
        // A timed-out run never accumulated a CDF, so there is nothing to compare.
        DONE:  if (!err_timeout_q) cdf_mismatch_q <= (cdf != frame_px);
        default: ;
      endcase
    end
  end

  assign div_start = (state == DIV) && !div_busy && !div_done;

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num_q),
    .divisor  (den_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.hist_calc_flag = (state == ARM);
  assign bus.hist_rd_en     = (state == READ);
  assign bus.hist_rd_addr   = (state == READ) ? bin : '0;
  assign bus.lut_we         = (state == WRITE);
  assign bus.lut_addr       = (state == WRITE) ? bin : '0;
  assign bus.lut_data       = (state == WRITE) ? value : '0;
  assign bus.err_timeout    = err_timeout_q;
  assign bus.cdf_mismatch   = cdf_mismatch_q;

endmodule

// File: tb/tb_hist_eq_lut_builder.sv
// Directed bench for hist_eq_lut_builder with a 1-cycle-latency histogram RAM model and a LUT write monitor.
module tb_hist_eq_lut_builder;
  import hist_eq_pkg::*;

  localparam int unsigned TMO = 100;

  logic microblaze_clk = 1'b0;
  logic rst;
  always #5 microblaze_clk = ~microblaze_clk;

  hist_eq_lut_builder_if bus();

  hist_eq_lut_builder #(.TIMEOUT(TMO)) dut (
    .clk (microblaze_clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] hist_mem [256];
  always @(posedge microblaze_clk)
    if (bus.hist_rd_en) bus.hist_rd_data <= hist_mem[bus.hist_rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int we_cnt, order_err, flag_cnt, done_cnt, arm_cyc, done_cyc, first_rd_cyc, busy_err;
  logic [7:0] lut_got [256];
  logic prev_done = 1'b0;

  always @(posedge microblaze_clk) cyc++;

  always @(negedge microblaze_clk) begin
    if (bus.lut_we) begin
      lut_got[bus.lut_addr] = bus.lut_data;
      if (int'(bus.lut_addr) != we_cnt) order_err++;
      we_cnt++;
    end
    if (bus.hist_calc_flag) begin flag_cnt++; arm_cyc = cyc; end
    if (bus.hist_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!bus.busy) busy_err++;
    end
    if (prev_done && bus.busy) busy_err++;
    if (bus.lut_we && !bus.busy) busy_err++;
    prev_done = bus.done;
  end

  task automatic tick();
    @(posedge microblaze_clk);
    #1;
  endtask

  task automatic mon_clear();
    we_cnt = 0; order_err = 0; flag_cnt = 0; done_cnt = 0;
    arm_cyc = -1000; done_cyc = 0; first_rd_cyc = -1; busy_err = 0;
    for (int i = 0; i < 256; i++) lut_got[i] = 8'd0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL wait_done: no done after %0d cycles, required within %0d", n, budget);
    end
  endtask

  task automatic run_hist(input logic [31:0] fp, input int budget);
    mon_clear();
    tick(); bus.start = 1'b1; bus.frame_pixels = fp;
    tick(); bus.start = 1'b0;
    tick(); bus.hist_valid = 1'b1;
    tick(); bus.hist_valid = 1'b0;
    wait_done(budget);
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.frame_pixels = '0; bus.hist_valid = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %0b, expected 0", bus.busy);
    end
    vectors++;
    if ({bus.hist_calc_flag, bus.hist_rd_en, bus.lut_we, bus.done, bus.err_timeout, bus.cdf_mismatch} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b, expected 000000",
               {bus.hist_calc_flag, bus.hist_rd_en, bus.lut_we, bus.done, bus.err_timeout, bus.cdf_mismatch});
    end
    vectors++;
    if ({bus.hist_rd_addr, bus.lut_addr, bus.lut_data} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_buses: got %h, expected 000000", {bus.hist_rd_addr, bus.lut_addr, bus.lut_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 256; i++) hist_mem[i] = 32'd1;
    run_hist(32'd256, 20000);
    vectors++;
    if (we_cnt !== 256) begin miscompares++; $display("FAIL uniform_we_cnt: got %0d, expected 256", we_cnt); end
    vectors++;
    if (order_err !== 0) begin miscompares++; $display("FAIL uniform_order: got %0d, expected 0", order_err); end
    for (int i = 0; i < 256; i++) begin
      vectors++;
      if (lut_got[i] !== 8'(i)) begin
        miscompares++; $display("FAIL uniform_lut[%0d]: got %0d, expected %0d", i, lut_got[i], i);
      end
    end
    vectors++;
    if (bus.cdf_mismatch !== 1'b0) begin miscompares++; $display("FAIL uniform_mismatch: got 1, expected 0"); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL uniform_done_cnt: got %0d, expected 1", done_cnt); end
    vectors++;
    if (flag_cnt !== 1) begin miscompares++; $display("FAIL uniform_flag_cnt: got %0d, expected 1", flag_cnt); end
    vectors++;
    if (busy_err !== 0) begin miscompares++; $display("FAIL uniform_busy: got %0d errors, expected 0", busy_err); end
  endtask

  task automatic test_divide();
    logic [7:0] exp_v;
    for (int i = 0; i < 256; i++) hist_mem[i] = 32'd0;
    hist_mem[0] = 32'd100; hist_mem[1] = 32'd200; hist_mem[2] = 32'd300; hist_mem[3] = 32'd400;
    run_hist(32'd1000, 20000);
    for (int i = 0; i < 256; i++) begin
      exp_v = (i == 0) ? 8'd0 : (i == 1) ? 8'd56 : (i == 2) ? 8'd141 : 8'd255;
      vectors++;
      if (lut_got[i] !== exp_v) begin
        miscompares++; $display("FAIL divide_lut[%0d]: got %0d, expected %0d", i, lut_got[i], exp_v);
      end
    end
    vectors++;
    if (bus.cdf_mismatch !== 1'b0) begin miscompares++; $display("FAIL divide_mismatch: got 1, expected 0"); end
  endtask

  task automatic test_single_bin();
    logic [7:0] exp_v;
    for (int i = 0; i < 256; i++) hist_mem[i] = 32'd0;
    hist_mem[100] = 32'd1000;
    run_hist(32'd1000, 3000);
    for (int i = 0; i < 256; i++) begin
      exp_v = (i < 100) ? 8'd0 : 8'd255;
      vectors++;
      if (lut_got[i] !== exp_v) begin
        miscompares++; $display("FAIL single_lut[%0d]: got %0d, expected %0d", i, lut_got[i], exp_v);
      end
    end
    vectors++;
    if (done_cyc - first_rd_cyc !== 768) begin
      miscompares++; $display("FAIL single_run_len: got %0d cycles, expected 768", done_cyc - first_rd_cyc);
    end
    vectors++;
    if (we_cnt !== 256) begin miscompares++; $display("FAIL single_we_cnt: got %0d, expected 256", we_cnt); end
  endtask

  task automatic test_mismatch();
    logic [7:0] exp_v;
    for (int i = 0; i < 256; i++) hist_mem[i] = 32'd0;
    hist_mem[0] = 32'd150; hist_mem[1] = 32'd150;
    run_hist(32'd256, 20000);
    for (int i = 0; i < 256; i++) begin
      exp_v = (i == 0) ? 8'd0 : 8'd255;
      vectors++;
      if (lut_got[i] !== exp_v) begin
        miscompares++; $display("FAIL mismatch_lut[%0d]: got %0d, expected %0d", i, lut_got[i], exp_v);
      end
    end
    vectors++;
    if (bus.cdf_mismatch !== 1'b1) begin miscompares++; $display("FAIL mismatch_flag: got 0, expected 1"); end
    vectors++;
    if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL mismatch_timeout: got 1, expected 0"); end
  endtask

  task automatic test_timeout();
    mon_clear();
    tick(); bus.start = 1'b1; bus.frame_pixels = 32'd50;
    tick(); bus.start = 1'b0;
    vectors++;
    if (bus.cdf_mismatch !== 1'b0) begin miscompares++; $display("FAIL timeout_mismatch_clear: got 1, expected 0"); end
    bus.hist_valid = 1'b1;
    tick(); bus.hist_valid = 1'b0;
    wait_done(500);
    tick(); tick();
    vectors++;
    if (bus.err_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_flag: got 0, expected 1"); end
    vectors++;
    if (done_cyc - arm_cyc !== 100) begin
      miscompares++; $display("FAIL timeout_latency: got %0d cycles, expected 100", done_cyc - arm_cyc);
    end
    vectors++;
    if (we_cnt !== 0) begin miscompares++; $display("FAIL timeout_we_cnt: got %0d, expected 0", we_cnt); end
    vectors++;
    if (first_rd_cyc !== -1) begin miscompares++; $display("FAIL timeout_read: got read at %0d, expected none", first_rd_cyc); end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL timeout_done_cnt: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_start_ignored_rst();
    int n;
    for (int i = 0; i < 256; i++) hist_mem[i] = 32'd1;
    mon_clear();
    tick(); bus.start = 1'b1; bus.frame_pixels = 32'd256;
    tick(); bus.start = 1'b0;
    vectors++;
    if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL restart_timeout_clear: got 1, expected 0"); end
    tick(); bus.hist_valid = 1'b1;
    tick(); bus.hist_valid = 1'b0;
    n = 0;
    while (!(bus.hist_rd_en && bus.hist_rd_addr == 8'd5) && n < 1000) begin tick(); n++; end
    vectors++;
    if (n >= 1000) begin miscompares++; $display("FAIL wait_read5: no read of bin 5 within %0d cycles", n); end
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    n = 0;
    while (!(bus.hist_rd_en && bus.hist_rd_addr == 8'd40) && n < 5000) begin tick(); n++; end
    vectors++;
    if (n >= 5000) begin miscompares++; $display("FAIL wait_read40: no read of bin 40 within %0d cycles", n); end
    repeat (7) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got 1, expected 0"); end
    vectors++;
    if ({bus.hist_calc_flag, bus.hist_rd_en, bus.lut_we, bus.done, bus.err_timeout, bus.cdf_mismatch,
         bus.hist_rd_addr, bus.lut_addr, bus.lut_data} !== 30'h0) begin
      miscompares++; $display("FAIL abort_outputs: got %h, expected 0",
        {bus.hist_calc_flag, bus.hist_rd_en, bus.lut_we, bus.done, bus.err_timeout, bus.cdf_mismatch,
         bus.hist_rd_addr, bus.lut_addr, bus.lut_data});
    end
    vectors++;
    if (flag_cnt !== 1) begin miscompares++; $display("FAIL abort_flag_cnt: got %0d, expected 1", flag_cnt); end
    vectors++;
    if (we_cnt !== 40) begin miscompares++; $display("FAIL abort_we_cnt: got %0d, expected 40", we_cnt); end
    vectors++;
    if (order_err !== 0) begin miscompares++; $display("FAIL abort_order: got %0d, expected 0", order_err); end
    tick(); tick();
    rst = 1'b0;
    tick();
    run_hist(32'd256, 20000);
    vectors++;
    if (we_cnt !== 256) begin miscompares++; $display("FAIL restart_we_cnt: got %0d, expected 256", we_cnt); end
    vectors++;
    if (order_err !== 0) begin miscompares++; $display("FAIL restart_order: got %0d, expected 0", order_err); end
    for (int i = 0; i < 256; i++) begin
      vectors++;
      if (lut_got[i] !== 8'(i)) begin
        miscompares++; $display("FAIL restart_lut[%0d]: got %0d, expected %0d", i, lut_got[i], i);
      end
    end
    vectors++;
    if (flag_cnt !== 1) begin miscompares++; $display("FAIL restart_flag_cnt: got %0d, expected 1", flag_cnt); end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_uniform();
    test_divide();
    test_single_bin();
    test_mismatch();
    test_timeout();
    test_start_ignored_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
